// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package mem_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Byte address that maps onto SRAM half-word pair 0.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Access sequencer states: a word access runs as a low half then a high half.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable 3-bit down-counter with terminal-count flag.
// It times one half-access: loaded with the wait count on entry to a phase,
// the phase ends in the cycle where tc_o is high.
module sram_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       tc_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == 3'd0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage responder between the EXE->MEM and MEM->WB registers.
// Each 32-bit load/store is carried out as two 16-bit SRAM accesses
// (low half first). ready stays low while an access is in flight so the
// hazard logic freezes the upstream pipeline.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned requests skip the
// SRAM entirely and raise align_err for the DONE cycle.
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [WORD_W-1:0]   addr,
    input  logic [WORD_W-1:0]   wr_data,
    output logic [WORD_W-1:0]   rd_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [HALF_W-1:0]   sram_dq_out,
    input  logic [HALF_W-1:0]   sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n,
    output logic                align_err
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    mem_state_e          state_q;
    mem_state_e          state_d;
    logic                is_write_q;
    logic [HALF_W-1:0]   wr_hi_q;
    logic [WORD_W-1:0]   rd_data_q;
    logic [SRAM_AW-1:0]  sram_addr_q;
    logic [HALF_W-1:0]   dq_out_q;
    logic                dq_oe_q;
    logic                we_n_q;
    logic                align_err_q;

    logic                req;
    logic                misaligned;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_tc;
    logic [31:0]         byte_off;
    logic [SRAM_AW-1:0]  half_base;
    logic                unused_off_bits;

    assign req = mem_r_en | mem_w_en;

    // Offset into the SRAM window; wraps modulo 2^32 for addresses below the base.
    assign byte_off        = addr - BASE_ADDR;
    assign half_base       = {byte_off[SRAM_AW:2], 1'b0};
    assign unused_off_bits = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    sram_wait_cnt u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    // Sequencer next state; the wait counter is reloaded on entry to each half.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LO;
                        cnt_load = 1'b1;
                    end
                end
            end
            LO: begin
                if (cnt_tc) begin
                    state_d  = HI;
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HI: begin
                if (cnt_tc) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, SRAM pin drive and read-data assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write_q  <= 1'b0;
            wr_hi_q     <= '0;
            rd_data_q   <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            align_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    if (req) begin
                        // A store wins when both enables are set.
                        is_write_q <= mem_w_en;
                        wr_hi_q    <= wr_data[31:16];
                        if (misaligned) begin
                            align_err_q <= 1'b1;
                        end else begin
                            sram_addr_q <= half_base;
                            we_n_q      <= ~mem_w_en;
                            dq_oe_q     <= mem_w_en;
                            if (mem_w_en) begin
                                dq_out_q <= wr_data[15:0];
                            end
                        end
                    end
                end
                LO: begin
                    if (cnt_tc) begin
                        sram_addr_q[0] <= 1'b1;
                        if (is_write_q) begin
                            dq_out_q <= wr_hi_q;
                        end else begin
                            rd_data_q[15:0] <= sram_dq_in;
                        end
                    end
                end
                HI: begin
                    if (cnt_tc) begin
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (!is_write_q) begin
                            rd_data_q[31:16] <= sram_dq_in;
                        end
                    end
                end
                default: begin
                    align_err_q <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline may advance on completion, or when idle with nothing requested.
    assign ready = rst
                 | (state_q == DONE)
                 | ((state_q == IDLE) & ~req);

    assign rd_data     = rd_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: one instance with one wait cycle
// per half access, one with zero wait cycles, each with its own SRAM model.
module tb_mem_stage_sram_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        r_en1, w_en1, r_en0, w_en0;

    logic [31:0] rd_data1, rd_data0;
    logic        ready1, ready0;
    logic [17:0] sram_addr1, sram_addr0;
    logic [15:0] dq_out1, dq_out0, dq_in1, dq_in0;
    logic        oe1, oe0, we_n1, we_n0, align1, align0;

    logic [15:0] mem1 [0:255];
    logic [15:0] mem0 [0:255];
    logic        load_pattern;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .mem_r_en(r_en1), .mem_w_en(w_en1), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data1), .ready(ready1), .sram_addr(sram_addr1),
        .sram_dq_out(dq_out1), .sram_dq_in(dq_in1), .sram_dq_oe(oe1),
        .sram_we_n(we_n1), .align_err(align1)
    );

    mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .mem_r_en(r_en0), .mem_w_en(w_en0), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data0), .ready(ready0), .sram_addr(sram_addr0),
        .sram_dq_out(dq_out0), .sram_dq_in(dq_in0), .sram_dq_oe(oe0),
        .sram_we_n(we_n0), .align_err(align0)
    );

    // Asynchronous-read SRAM models, written on the clock edge while we_n is low.
    assign dq_in1 = mem1[sram_addr1[7:0]];
    assign dq_in0 = mem0[sram_addr0[7:0]];

    always @(posedge clk) begin
        if (load_pattern) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 16'(16'hA500 + i);
                mem0[i] <= 16'(16'h5A00 + i);
            end
        end else begin
            if (!we_n1) mem1[sram_addr1[7:0]] <= dq_out1;
            if (!we_n0) mem0[sram_addr0[7:0]] <= dq_out0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; load_pattern = 1'b1;
        r_en1 = 1'b0; w_en1 = 1'b0; r_en0 = 1'b0; w_en0 = 1'b0;
        addr = 32'd0; wr_data = 32'd0;
        tick;
        load_pattern = 1'b0;
        tick;
        total_cnt++;
        if (u_dut_w1.state_q !== IDLE) $display("FAIL reset_state: got %0d expected %0d", u_dut_w1.state_q, IDLE);
        else pass_cnt++;
        total_cnt++;
        if ({ready1, we_n1, oe1, align1} !== 4'b1100) $display("FAIL reset_ctrl {ready,we_n,oe,align}: got %b expected 1100", {ready1, we_n1, oe1, align1});
        else pass_cnt++;
        total_cnt++;
        if ({rd_data1, sram_addr1, dq_out1} !== 66'd0) $display("FAIL reset_data rd=%h addr=%h dq=%h expected all zero", rd_data1, sram_addr1, dq_out1);
        else pass_cnt++;
        r_en1 = 1'b1;
        #1;
        total_cnt++;
        if (ready1 !== 1'b1) $display("FAIL reset_ready_with_req: got %b expected 1", ready1);
        else pass_cnt++;
        r_en1 = 1'b0;
        rst = 1'b0;
        tick;
        $display("reset: done");
    endtask

    task automatic test_write;
        w_en1 = 1'b1; addr = 32'd1024; wr_data = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (ready1 !== 1'b0) $display("FAIL write_c0_ready: got %b expected 0", ready1);
        else pass_cnt++;
        for (int c = 1; c <= 5; c++) begin
            tick;
            if (c < 5) begin
                total_cnt++;
                if ({ready1, we_n1, oe1} !== 3'b001) $display("FAIL write_c%0d_ctrl {ready,we_n,oe}: got %b expected 001", c, {ready1, we_n1, oe1});
                else pass_cnt++;
                total_cnt++;
                if (sram_addr1 !== ((c < 3) ? 18'd0 : 18'd1)) $display("FAIL write_c%0d_addr: got %0d expected %0d", c, sram_addr1, (c < 3) ? 0 : 1);
                else pass_cnt++;
                total_cnt++;
                if (dq_out1 !== ((c < 3) ? 16'hBEEF : 16'hDEAD)) $display("FAIL write_c%0d_dq: got %h expected %h", c, dq_out1, (c < 3) ? 16'hBEEF : 16'hDEAD);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if ({ready1, we_n1, oe1} !== 3'b110) $display("FAIL write_done_ctrl {ready,we_n,oe}: got %b expected 110", {ready1, we_n1, oe1});
                else pass_cnt++;
            end
        end
        w_en1 = 1'b0;
        tick;
        total_cnt++;
        if ({mem1[1], mem1[0]} !== 32'hDEAD_BEEF) $display("FAIL write_sram_contents: got %h expected deadbeef", {mem1[1], mem1[0]});
        else pass_cnt++;
        $display("write addr=1024 data=deadbeef");
    endtask

    task automatic test_read;
        r_en1 = 1'b1; addr = 32'd1024;
        #1;
        total_cnt++;
        if (ready1 !== 1'b0) $display("FAIL read_c0_ready: got %b expected 0", ready1);
        else pass_cnt++;
        for (int c = 1; c <= 5; c++) begin
            tick;
            total_cnt++;
            if ({ready1, we_n1, oe1} !== ((c < 5) ? 3'b010 : 3'b110)) $display("FAIL read_c%0d_ctrl {ready,we_n,oe}: got %b expected %b", c, {ready1, we_n1, oe1}, (c < 5) ? 3'b010 : 3'b110);
            else pass_cnt++;
            if (c == 3) begin
                total_cnt++;
                if (sram_addr1 !== 18'd1) $display("FAIL read_hi_addr: got %0d expected 1", sram_addr1);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (rd_data1 !== 32'hDEAD_BEEF) $display("FAIL read_data: got %h expected deadbeef", rd_data1);
        else pass_cnt++;
        r_en1 = 1'b0;
        tick;
        $display("read addr=1024 data=%h", rd_data1);
    endtask

    task automatic test_both_enables;
        r_en1 = 1'b1; w_en1 = 1'b1; addr = 32'd1028; wr_data = 32'd1;
        for (int c = 1; c <= 5; c++) begin
            tick;
            if (c == 1) begin
                total_cnt++;
                if ({sram_addr1, dq_out1, we_n1} !== {18'd2, 16'h0001, 1'b0}) $display("FAIL both_lo addr=%0d dq=%h we_n=%b expected 2/0001/0", sram_addr1, dq_out1, we_n1);
                else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if ({sram_addr1, dq_out1, we_n1} !== {18'd3, 16'h0000, 1'b0}) $display("FAIL both_hi addr=%0d dq=%h we_n=%b expected 3/0000/0", sram_addr1, dq_out1, we_n1);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({ready1, rd_data1} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL both_done ready=%b rd=%h expected 1/deadbeef", ready1, rd_data1);
        else pass_cnt++;
        r_en1 = 1'b0; w_en1 = 1'b0;
        tick;
        total_cnt++;
        if ({mem1[3], mem1[2]} !== 32'h0000_0001) $display("FAIL both_sram_contents: got %h expected 00000001", {mem1[3], mem1[2]});
        else pass_cnt++;
        $display("write(both) addr=1028 data=00000001");
    endtask

    task automatic test_align;
        logic [17:0] addr_before;
        addr_before = sram_addr1;
        r_en1 = 1'b1; addr = 32'd1025;
        #1;
        total_cnt++;
        if (ready1 !== 1'b0) $display("FAIL align_c0_ready: got %b expected 0", ready1);
        else pass_cnt++;
`ifdef MEM_ALIGN_CHECK_EN
        tick;
        total_cnt++;
        if ({ready1, align1, we_n1, oe1} !== 4'b1110) $display("FAIL align_done {ready,align,we_n,oe}: got %b expected 1110", {ready1, align1, we_n1, oe1});
        else pass_cnt++;
        total_cnt++;
        if ({rd_data1, sram_addr1} !== {32'hDEAD_BEEF, addr_before}) $display("FAIL align_hold rd=%h addr=%0d expected deadbeef/%0d", rd_data1, sram_addr1, addr_before);
        else pass_cnt++;
        r_en1 = 1'b0;
        tick;
        total_cnt++;
        if ({ready1, align1} !== 2'b10) $display("FAIL align_clear {ready,align}: got %b expected 10", {ready1, align1});
        else pass_cnt++;
`else
        for (int c = 1; c <= 5; c++) begin
            tick;
            total_cnt++;
            if ({ready1, align1} !== ((c < 5) ? 2'b00 : 2'b10)) $display("FAIL align_c%0d {ready,align}: got %b expected %b", c, {ready1, align1}, (c < 5) ? 2'b00 : 2'b10);
            else pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if (sram_addr1 !== 18'd0) $display("FAIL align_word0_addr: got %0d expected 0", sram_addr1);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (rd_data1 !== 32'hDEAD_BEEF) $display("FAIL align_read_data: got %h expected deadbeef", rd_data1);
        else pass_cnt++;
        r_en1 = 1'b0;
        tick;
`endif
        $display("read addr=1025 (unaligned) rd=%h addr_before=%0d", rd_data1, addr_before);
    endtask

    task automatic test_reset_mid_write;
        w_en1 = 1'b1; addr = 32'd1040; wr_data = 32'h1234_5678;
        repeat (3) tick;
        total_cnt++;
        if (u_dut_w1.state_q !== HI) $display("FAIL midrst_reach_hi: got %0d expected %0d", u_dut_w1.state_q, HI);
        else pass_cnt++;
        rst = 1'b1; w_en1 = 1'b0;
        #1;
        total_cnt++;
        if ({ready1, we_n1, oe1} !== 3'b110) $display("FAIL midrst_async {ready,we_n,oe}: got %b expected 110", {ready1, we_n1, oe1});
        else pass_cnt++;
        tick;
        total_cnt++;
        if (u_dut_w1.state_q !== IDLE) $display("FAIL midrst_state: got %0d expected %0d", u_dut_w1.state_q, IDLE);
        else pass_cnt++;
        total_cnt++;
        if ({ready1, we_n1, oe1, rd_data1} !== {3'b110, 32'd0}) $display("FAIL midrst_outputs ready/we_n/oe=%b rd=%h expected 110/0", {ready1, we_n1, oe1}, rd_data1);
        else pass_cnt++;
        rst = 1'b0;
        tick;
        total_cnt++;
        if ({mem1[9], mem1[8]} !== 32'hA509_5678) $display("FAIL midrst_partial_write: got %h expected a5095678", {mem1[9], mem1[8]});
        else pass_cnt++;
        $display("write addr=1040 aborted by reset");
    endtask

    task automatic test_back_to_back;
        r_en0 = 1'b1; addr = 32'd1032;
        #1;
        total_cnt++;
        if (ready0 !== 1'b0) $display("FAIL b2b_c0_ready: got %b expected 0", ready0);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ready0, sram_addr0} !== {1'b0, 18'd4}) $display("FAIL b2b_first_lo ready=%b addr=%0d expected 0/4", ready0, sram_addr0);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ready0, sram_addr0} !== {1'b0, 18'd5}) $display("FAIL b2b_first_hi ready=%b addr=%0d expected 0/5", ready0, sram_addr0);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ready0, rd_data0} !== {1'b1, 32'h5A05_5A04}) $display("FAIL b2b_first_done ready=%b rd=%h expected 1/5a055a04", ready0, rd_data0);
        else pass_cnt++;
        $display("read addr=1032 data=%h", rd_data0);
        addr = 32'd1036;
        tick;
        total_cnt++;
        if ({ready0, u_dut_w0.state_q} !== {1'b0, IDLE}) $display("FAIL b2b_second_accept ready=%b state=%0d expected 0/%0d", ready0, u_dut_w0.state_q, IDLE);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ready0, sram_addr0} !== {1'b0, 18'd6}) $display("FAIL b2b_second_lo ready=%b addr=%0d expected 0/6", ready0, sram_addr0);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ready0, sram_addr0} !== {1'b0, 18'd7}) $display("FAIL b2b_second_hi ready=%b addr=%0d expected 0/7", ready0, sram_addr0);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ready0, rd_data0} !== {1'b1, 32'h5A07_5A06}) $display("FAIL b2b_second_done ready=%b rd=%h expected 1/5a075a06", ready0, rd_data0);
        else pass_cnt++;
        r_en0 = 1'b0;
        tick;
        total_cnt++;
        if (ready0 !== 1'b1) $display("FAIL b2b_idle_ready: got %b expected 1", ready0);
        else pass_cnt++;
        $display("read addr=1036 data=%h", rd_data0);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_both_enables;
        test_align;
        test_reset_mid_write;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
